pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-bit-PC RISC-V core. Sits beside fetch_decode and
//  drives its stall/flush controls: detects load-use hazards, flushes wrong-path
//  instructions after a taken jump, and drains the pipeline before a halt.
//  Single arbitration point for all PC-hold / bubble decisions.
// PARAMETERS
//  REG_W         5   register-index width
//  FLUSH_CYCLES  2   cycles of flush after a taken jump (>=1)
//  DRAIN_CYCLES  3   cycles of nop injection after halt before halted asserts (>=1)
//  CNT_W         16  perf-counter width (PERF_CNT_EN only)
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  id_rr1         in   REG_W  rs1 index of instruction in decode
//  id_rr2         in   REG_W  rs2 index of instruction in decode
//  id_uses_rs1    in   1      decode instruction reads rs1
//  id_uses_rs2    in   1      decode instruction reads rs2
//  ex_write_reg   in   REG_W  rd of instruction in execute
//  ex_mem_to_reg  in   1      execute instruction is a load
//  ex_reg_wren    in   1      execute instruction writes rd
//  should_jump    in   1      taken jump/branch resolved in execute
//  halt_detect    in   1      decode sees a halt instruction
//  pc_hold        out  1      freeze PC this cycle
//  ifid_hold      out  1      freeze IF/ID register this cycle
//  ifid_flush     out  1      replace fetched instruction with nop (0x00000013)
//  idex_bubble    out  1      insert nop into ID/EX register
//  halted         out  1      pipeline drained and stopped
//  stall_cnt      out  CNT_W  load-use stall cycles (PERF_CNT_EN only)
//  flush_cnt      out  CNT_W  flush/drain cycles (PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=RUN, all outputs 0, internal counters 0.
//  - FSM states: RUN, FLUSH, DRAIN, HALTED. Registered state; outputs are
//    combinational from state + inputs (zero-cycle reaction).
//  - load_use = ex_mem_to_reg & ex_reg_wren & ex_write_reg!=0 &
//    ((id_uses_rs1 & id_rr1==ex_write_reg) | (id_uses_rs2 & id_rr2==ex_write_reg)).
//    x0 never causes a hazard.
//  - Priority, highest first: should_jump > halt_detect > load_use.
//  - RUN, should_jump: ifid_flush=1, idex_bubble=1, pc_hold=0 (PC loads target).
//    If FLUSH_CYCLES>1 -> FLUSH with cnt=FLUSH_CYCLES-1, else stay RUN.
//  - RUN, load_use (no jump): pc_hold=ifid_hold=idex_bubble=1 for exactly that
//    cycle; state stays RUN (bubble in EX removes the hazard next cycle).
//  - RUN, halt_detect (no jump): idex_bubble=0 (halt passes as nop); -> DRAIN,
//    cnt=DRAIN_CYCLES. load_use same cycle is ignored.
//  - FLUSH: ifid_flush=idex_bubble=1; cnt-- each cycle; cnt==1 -> RUN.
//    should_jump in FLUSH restarts cnt at FLUSH_CYCLES-1. halt_detect ignored.
//  - DRAIN: pc_hold=1, ifid_flush=1; cnt-- each cycle; cnt==1 -> HALTED.
//    should_jump in DRAIN (older instruction) cancels halt: pc_hold=0,
//    ifid_flush=idex_bubble=1, -> FLUSH (or RUN if FLUSH_CYCLES==1).
//  - HALTED: halted=1, pc_hold=1, ifid_flush=1; all inputs ignored; exit only
//    via rst_n. Reset mid-FLUSH/DRAIN returns to RUN immediately.
//  - ifid_hold never asserted together with ifid_flush.
// CONFIGURATION
//  PERF_CNT_EN defined: stall_cnt +1 per cycle load_use stalls; flush_cnt +1 per
//   cycle ifid_flush=1 outside HALTED; both saturate at 2^CNT_W-1; reset to 0.
//  PERF_CNT_EN undefined: stall_cnt/flush_cnt ports absent, no counter logic.
// TESTING
//  1 load x5 in EX, decode reads rs1=x5 -> one cycle pc_hold=ifid_hold=idex_bubble=1.
//  2 load x0 in EX, decode reads x0 -> no stall; non-load ALU write x5 -> no stall.
//  3 should_jump 1 cycle, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, pc_hold=0.
//  4 halt_detect in RUN -> pc_hold=1 for 3 DRAIN cycles, halted=1 on 4th, stays.
//  5 should_jump in 2nd DRAIN cycle -> halt cancelled, FLUSH, halted never rises.
//  6 rst_n low mid-DRAIN -> outputs 0 asynchronously; PERF_CNT_EN counts match 1-4.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for the 5-bit-PC RISC-V core.
// Handles load-use stalls, wrong-path flushes after taken jumps, and the
// pipeline drain that comes before a halt.
// Optional feature macro: PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rr1,
  input  logic [REG_W-1:0] id_rr2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_wren,
  input  logic             should_jump,
  input  logic             halt_detect,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MAXC = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD   = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          load_use;

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_mem_to_reg & ex_reg_wren & (ex_write_reg != '0) &
                    ((id_uses_rs1 & (id_rr1 == ex_write_reg)) |
                     (id_uses_rs2 & (id_rr2 == ex_write_reg)));

  // State and cycle-count registers; reset drops any flush or drain in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next-state and output decode: jump beats halt beats load-use, outputs react in the same cycle.
  always_comb begin
    next_state  = state;
    next_cnt    = cnt;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    case (state)
      RUN: begin
        if (should_jump) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            next_state = FLUSH;
            next_cnt   = FLUSH_RELOAD;
          end
        end else if (halt_detect) begin
          next_state = DRAIN;
          next_cnt   = DRAIN_LOAD;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (should_jump) begin
          next_cnt = FLUSH_RELOAD;
        end else if (cnt == CNT_ONE) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      DRAIN: begin
        if (should_jump) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            next_state = FLUSH;
            next_cnt   = FLUSH_RELOAD;
          end else begin
            next_state = RUN;
            next_cnt   = '0;
          end
        end else begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          if (cnt == CNT_ONE) begin
            next_state = HALTED;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt - CNT_ONE;
          end
        end
      end
      HALTED: begin
        halted     = 1'b1;
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
      end
      default: begin
        next_state = RUN;
        next_cnt   = '0;
      end
    endcase
    if (!rst_n) begin
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = ifid_hold;
  assign flush_evt = ifid_flush & (state != HALTED);

  // Saturating performance counters for stall cycles and flush/drain cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Without PERF_CNT_EN this build carries no performance counters.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl.
// Expected output vectors are {pc_hold, ifid_hold, ifid_flush, idex_bubble, halted}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rr1 = '0;
  logic [4:0] id_rr2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] ex_write_reg = '0;
  logic       ex_mem_to_reg = 1'b0;
  logic       ex_reg_wren = 1'b0;
  logic       should_jump = 1'b0;
  logic       halt_detect = 1'b0;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, halted;
`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  typedef struct {
    string    name;
    logic [4:0] outs;
    int       stalls;
    int       flushes;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stallAcc = 0;
  int   flushAcc = 0;

  pipe_hazard_ctrl #(
    .REG_W(5), .FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rr1(id_rr1), .id_rr2(id_rr2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_write_reg(ex_write_reg), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_wren(ex_reg_wren),
    .should_jump(should_jump), .halt_detect(halt_detect),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .halted(halted)
`ifdef PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Record an expected vector; counter expectations reflect all earlier cycles.
  task automatic pushExp(input string nm, input logic [4:0] ev);
    exp_t e;
    e.name    = nm;
    e.outs    = ev;
    e.stalls  = stallAcc;
    e.flushes = flushAcc;
    expQ.push_back(e);
    if (ev[3]) stallAcc++;
    if (ev[2] && !ev[0]) flushAcc++;
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic applyStimulus(input string nm,
                               input logic [4:0] rr1, input logic [4:0] rr2,
                               input logic u1, input logic u2,
                               input logic [4:0] exw, input logic mtr, input logic wren,
                               input logic jmp, input logic hlt, input logic [4:0] ev);
    @(posedge clk);
    #1;
    id_rr1 = rr1; id_rr2 = rr2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_write_reg = exw; ex_mem_to_reg = mtr; ex_reg_wren = wren;
    should_jump = jmp; halt_detect = hlt;
    pushExp(nm, ev);
  endtask

  // Change reset mid-cycle with idle inputs; asserting it must clear outputs before the next edge.
  task automatic applyReset(input string nm, input logic level);
    @(posedge clk);
    #1;
    id_rr1 = '0; id_rr2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_write_reg = '0; ex_mem_to_reg = 0; ex_reg_wren = 0;
    should_jump = 0; halt_detect = 0;
    rst_n = level;
    if (!level) begin
      stallAcc = 0;
      flushAcc = 0;
    end
    pushExp(nm, 5'b00000);
  endtask

  // Monitor: sample mid-cycle on the falling edge and compare against the scoreboard head.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic checkOutput(input exp_t e);
    logic [4:0] act;
    act = {pc_hold, ifid_hold, ifid_flush, idex_bubble, halted};
    checks++;
    if (act !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s: outputs got %b expected %b", e.name, act, e.outs);
    end
`ifdef PERF_CNT_EN
    checks++;
    if ((stall_cnt !== 16'(e.stalls)) || (flush_cnt !== 16'(e.flushes))) begin
      errors++;
      $display("[TB] FAIL %s_perf: stall/flush got %0d/%0d expected %0d/%0d",
               e.name, stall_cnt, flush_cnt, e.stalls, e.flushes);
    end
`endif
  endtask

  // Absolute time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, queue=%0d expected 0", expQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus; arguments: rr1 rr2 u1 u2 exw mtr wren jump halt expected.
  initial begin
    applyReset("reset_hold", 1'b0);
    applyReset("reset_release", 1'b1);
    applyStimulus("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("lu_rs1_x5",     5, 0, 1, 0, 5, 1, 1, 0, 0, 5'b11010);
    applyStimulus("lu_cleared",    5, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("lu_rs2_x7",     0, 7, 0, 1, 7, 1, 1, 0, 0, 5'b11010);
    applyStimulus("rs2_unused",    0, 7, 0, 0, 7, 1, 1, 0, 0, 5'b00000);
    applyStimulus("load_x0",       0, 0, 1, 1, 0, 1, 1, 0, 0, 5'b00000);
    applyStimulus("alu_x5",        5, 0, 1, 0, 5, 0, 1, 0, 0, 5'b00000);
    applyStimulus("load_nowren",   5, 0, 1, 0, 5, 1, 0, 0, 0, 5'b00000);
    applyStimulus("jump",          0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00110);
    applyStimulus("flush_ign",     5, 0, 1, 0, 5, 1, 1, 0, 1, 5'b00110);
    applyStimulus("after_flush",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("jump_prio",     5, 0, 1, 0, 5, 1, 1, 1, 1, 5'b00110);
    applyStimulus("flush_rejump",  0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00110);
    applyStimulus("flush_last",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110);
    applyStimulus("run_again",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("halt_over_lu",  5, 0, 1, 0, 5, 1, 1, 0, 1, 5'b00000);
    applyStimulus("drain1",        0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100);
    applyStimulus("drain2",        0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100);
    applyStimulus("drain3",        0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100);
    applyStimulus("halted_ign",    5, 0, 1, 0, 5, 1, 1, 1, 0, 5'b10101);
    applyStimulus("halted_stay",   0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10101);
    applyReset("reset_halted", 1'b0);
    applyReset("release2", 1'b1);
    applyStimulus("halt2",         0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
    applyStimulus("drain2_1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100);
    applyStimulus("drain2_jump",   0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00110);
    applyStimulus("cancel_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110);
    applyStimulus("no_halt_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("no_halt_b",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    applyStimulus("halt3",         0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000);
    applyStimulus("drain3_1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100);
    applyReset("reset_drain", 1'b0);
    applyReset("release3", 1'b1);
    applyStimulus("final_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000);
    repeat (4) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_queue: %0d entries left expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
